// File: rtl/regfile.sv
// regfile: 32 x 32-bit processor register file.
// One synchronous write port, two combinational read ports (A and B),
// register 0 hardwired to zero, optional same-cycle write-to-read bypass.
// Registers 1..31 are individual register_32 instances with an async clear.

// register_32: one 32-bit storage word with async active-high clear and
// a write enable sampled at the rising clock edge.
module register_32 (
    input  logic        clock,
    input  logic        clr,
    input  logic        in_enable,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    // Stored word: cleared immediately by clr, loaded on enabled rising edges.
    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            data_out <= '0;
        end else if (in_enable) begin
            data_out <= data_in;
        end
    end

endmodule

module regfile #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB
);

    logic        clr;
    logic [31:1] write_dec;
    logic [31:1] write_en;
    logic [31:0] stored [32];
    logic        write_live;
    logic        bypass_a;
    logic        bypass_b;

    // The storage cells clear on a high level; reset is active-low at the pins.
    assign clr = ~clr_n;

    // Index 0 has no storage and always reads as zero.
    assign stored[0] = '0;

    // 5-to-32 one-hot write decode; slot 0 is never decoded, so writes to r0
    // vanish. Gating with clr_n keeps a write from racing the clear.
    // NOTE: outputs get a default first so no path through the loop infers a latch.
    always_comb begin
        write_dec = '0;
        write_en  = '0;
        for (int i = 1; i < 32; i++) begin
            write_dec[i] = (ctrl_writeReg == 5'(i));
            write_en[i]  = ctrl_writeEnable && write_dec[i] && clr_n;
        end
    end

    genvar g;
    generate
        for (g = 1; g < 32; g++) begin : g_reg
            register_32 u_reg (
                .clock     (clock),
                .clr       (clr),
                .in_enable (write_en[g]),
                .data_in   (data_writeReg),
                .data_out  (stored[g])
            );
        end
    endgenerate

    // A write that will actually land this cycle; never true for r0 or in reset.
    assign write_live = ctrl_writeEnable && clr_n && (ctrl_writeReg != 5'd0);
    assign bypass_a   = BYPASS && write_live && (ctrl_readRegA == ctrl_writeReg);
    assign bypass_b   = BYPASS && write_live && (ctrl_readRegB == ctrl_writeReg);

    // Read port A: stored word, overridden by in-flight write data when bypassing.
    always_comb begin
        data_readRegA = stored[ctrl_readRegA];
        if (bypass_a) begin
            data_readRegA = data_writeReg;
        end
    end

    // Read port B: independent of port A, same selection rules.
    always_comb begin
        data_readRegB = stored[ctrl_readRegB];
        if (bypass_b) begin
            data_readRegB = data_writeReg;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
// Two instances share every input: one with bypass enabled, one without,
// so the same stimulus shows both same-cycle behaviours.
`timescale 1ns/1ps
module tb_regfile;

    logic        clock;
    logic        clr_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] a_byp, b_byp, a_nob, b_nob;

    int checks = 0;
    int errors = 0;

    regfile #(.BYPASS(1'b1)) dut_byp (
        .clock            (clock),
        .clr_n            (clr_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a_byp),
        .data_readRegB    (b_byp)
    );

    regfile #(.BYPASS(1'b0)) dut_nob (
        .clock            (clock),
        .clr_n            (clr_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (a_nob),
        .data_readRegB    (b_nob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One enabled write captured at the next rising edge.
    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = idx;
        data_writeReg    = data;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
    endtask

    initial begin
        clr_n            = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h0;
        ctrl_readRegA    = 5'd1;
        ctrl_readRegB    = 5'd31;

        // Reset state
        #12;
        check("reset_a_byp", a_byp, 32'h0);
        check("reset_b_byp", b_byp, 32'h0);
        check("reset_a_nob", a_nob, 32'h0);
        check("reset_b_nob", b_nob, 32'h0);
        @(negedge clock);
        clr_n = 1'b1;

        // Async reset clears r5 without a clock edge
        wr(5'd5, 32'hDEAD_BEEF);
        @(negedge clock);
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd5;
        #1;
        check("r5_written_a", a_nob, 32'hDEAD_BEEF);
        check("r5_written_b", b_nob, 32'hDEAD_BEEF);
        #1 clr_n = 1'b0;
        #2;
        check("r5_async_clr_a", a_nob, 32'h0);
        check("r5_async_clr_b", b_byp, 32'h0);
        #5 clr_n = 1'b1;
        #1;
        check("r5_after_pulse", a_nob, 32'h0);

        // Write i*0x01010101 to every register, then sweep A up and B down
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h0101_0101);
        end
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check($sformatf("sweep_a_r%0d", i), a_nob, 32'(i) * 32'h0101_0101);
            check($sformatf("sweep_b_r%0d", 31 - i), b_byp, 32'(31 - i) * 32'h0101_0101);
        end

        // Register 0 protection
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFF_FFFF;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        #1;
        check("r0_during_a_byp", a_byp, 32'h0);
        check("r0_during_b_byp", b_byp, 32'h0);
        @(posedge clock);
        #1;
        check("r0_after_a", a_nob, 32'h0);
        check("r0_after_b", b_byp, 32'h0);
        ctrl_writeEnable = 1'b0;

        // Enable gating: r7 holds 25 while enable is low
        wr(5'd7, 32'd25);
        @(negedge clock);
        ctrl_writeReg = 5'd7;
        data_writeReg = 32'd28;
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd7;
        repeat (3) @(posedge clock);
        #1;
        check("r7_hold_nob", a_nob, 32'd25);
        check("r7_hold_byp", b_byp, 32'd25);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        #1;
        check("r7_bypass_pre", a_byp, 32'd28);
        check("r7_nobypass_pre", a_nob, 32'd25);
        @(posedge clock);
        #1;
        check("r7_written_nob", a_nob, 32'd28);
        check("r7_written_byp", b_byp, 32'd28);
        ctrl_writeEnable = 1'b0;

        // Bypass: r9 holds 0x09090909 from the sweep
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h1234_5678;
        ctrl_readRegA    = 5'd9;
        ctrl_readRegB    = 5'd9;
        #1;
        check("byp_pre_a", a_byp, 32'h1234_5678);
        check("byp_pre_b", b_byp, 32'h1234_5678);
        check("nob_pre_a", a_nob, 32'h0909_0909);
        check("nob_pre_b", b_nob, 32'h0909_0909);
        @(posedge clock);
        #1;
        check("nob_post_a", a_nob, 32'h1234_5678);
        check("nob_post_b", b_nob, 32'h1234_5678);
        ctrl_writeEnable = 1'b0;

        // Bypass is per port: B reads a different register
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'hCAFE_F00D;
        ctrl_readRegA    = 5'd9;
        ctrl_readRegB    = 5'd8;
        #1;
        check("byp_indep_a", a_byp, 32'hCAFE_F00D);
        check("byp_indep_b", b_byp, 32'h0808_0808);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;

        // Back-to-back writes to r4: last one wins
        wr(5'd4, 32'h0000_0001);
        wr(5'd4, 32'h0000_0002);
        ctrl_readRegA = 5'd4;
        #1;
        check("r4_last_wins", a_nob, 32'h0000_0002);

        // Reset asserted during a write to r3
        @(negedge clock);
        clr_n            = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'hAAAA_5555;
        ctrl_readRegA    = 5'd3;
        ctrl_readRegB    = 5'd9;
        #1;
        check("r3_rst_nobypass", a_byp, 32'h0);
        @(posedge clock);
        #1;
        check("r3_rst_edge", a_nob, 32'h0);
        check("r9_rst_cleared", b_nob, 32'h0);
        @(negedge clock);
        clr_n = 1'b1;
        #1;
        check("r3_release_byp", a_byp, 32'hAAAA_5555);
        check("r3_release_nob", a_nob, 32'h0);
        @(posedge clock);
        #1;
        check("r3_written", a_nob, 32'hAAAA_5555);
        ctrl_writeEnable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
